// File: rtl/shadowmask_loader.sv
// Shadow-mask overlay loader: on start it fetches a preset (header word plus
// 64 three-bit LUT entries) from pattern memory and writes it to the mask's
// command port. Single host commands share the port through a one-entry slot.
// A loader write always wins the port; the slot drains in non-writing cycles.
module shadowmask_loader #(
  parameter int ADDR_W        = 8,
  parameter int PRESET_STRIDE = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        preset,
  input  logic [2:0]        cfg,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  input  logic              host_wr,
  input  logic [15:0]       host_cmd,
  output logic              host_ready,
  output logic              cmd_wr,
  output logic [15:0]       cmd_in,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_DIS, S_HDR, S_WV, S_WH, S_FETCH,
    S_LUT0, S_LUT1, S_LUT2, S_LUT3, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          n_q, n_d;          // memory word index within the preset
  logic [2:0]          preset_q, cfg_q;
  logic [11:0]         data_q;            // last fetched word (payload bits only)
  logic                rom_rd_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                cmd_wr_q, busy_q, done_q;
  logic [15:0]         cmd_in_q;
  logic                slot_full_q;
  logic [15:0]         slot_q;

  logic                rom_hit;
  logic                rd_d;
  logic [ADDR_W-1:0]   base;
  logic [11:0]         word;
  logic [3:0]          lut_grp;
  logic                ld_wr;
  logic [15:0]         ld_cmd;
  logic                issue;
  logic                unused_hi;

  // Header bits [15:8] and LUT word bits [15:12] carry no information.
  assign unused_hi = ^rom_data[15:12];

  // An ack only counts while a read is actually outstanding.
  assign rom_hit = rom_rd_q & rom_ack;
  assign base    = ADDR_W'(int'(preset_q) * PRESET_STRIDE);
  assign rd_d    = (state_d == S_HDR) || (state_d == S_FETCH);

  // Next-state and word-index sequencing.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      S_IDLE:  if (start) begin
                 state_d = S_DIS;
                 n_d     = 5'd0;
               end
      S_DIS:   state_d = S_HDR;
      S_HDR:   if (rom_hit) state_d = S_WV;
      S_WV:    state_d = S_WH;
      S_WH:    begin
                 state_d = S_FETCH;
                 n_d     = 5'd1;
               end
      S_FETCH: if (rom_hit) state_d = S_LUT0;
      S_LUT0:  state_d = S_LUT1;
      S_LUT1:  state_d = S_LUT2;
      S_LUT2:  state_d = S_LUT3;
      S_LUT3:  if (n_q == 5'd16) begin
                 state_d = S_FIN;
               end else begin
                 state_d = S_FETCH;
                 n_d     = n_q + 5'd1;
               end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Loader command for the state being entered; the word just acked is used
  // directly so the write can follow the ack by one cycle.
  // LUT layout: {3'b011, 3'b000, idx[5:0], 1'b0, entry[2:0]}.
  always_comb begin
    word    = rom_hit ? rom_data[11:0] : data_q;
    lut_grp = n_q[3:0] - 4'd1;
    ld_wr   = 1'b1;
    ld_cmd  = 16'h0000;
    unique case (state_d)
      S_DIS:   ld_cmd = 16'h0000;
      S_WV:    ld_cmd = {3'b001, 9'b0, word[7:4]};
      S_WH:    ld_cmd = {3'b010, 9'b0, word[3:0]};
      S_LUT0:  ld_cmd = {3'b011, 3'b000, lut_grp, 2'd0, 1'b0, word[2:0]};
      S_LUT1:  ld_cmd = {3'b011, 3'b000, lut_grp, 2'd1, 1'b0, word[5:3]};
      S_LUT2:  ld_cmd = {3'b011, 3'b000, lut_grp, 2'd2, 1'b0, word[8:6]};
      S_LUT3:  ld_cmd = {3'b011, 3'b000, lut_grp, 2'd3, 1'b0, word[11:9]};
      S_FIN:   ld_cmd = {13'b0, cfg_q};
      default: ld_wr  = 1'b0;
    endcase
  end

  // Host slot drains only into cycles the loader leaves free.
  assign issue = slot_full_q & ~ld_wr;

  // FSM state, memory interface, command port and host slot registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= 5'd0;
      preset_q    <= 3'd0;
      cfg_q       <= 3'd0;
      data_q      <= 12'd0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_in_q    <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      slot_full_q <= 1'b0;
      slot_q      <= 16'h0000;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      if (state_q == S_IDLE && start) begin
        preset_q <= preset;
        cfg_q    <= cfg;
      end
      if (rom_hit) data_q <= rom_data[11:0];
      rom_rd_q <= rd_d;
      if (rd_d) rom_addr_q <= base + ADDR_W'(n_d);

      cmd_wr_q <= ld_wr | issue;
      if (ld_wr)      cmd_in_q <= ld_cmd;
      else if (issue) cmd_in_q <= slot_q;

      if (issue) begin
        slot_full_q <= 1'b0;
      end else if (host_wr && !slot_full_q) begin
        slot_full_q <= 1'b1;
        slot_q      <= host_cmd;
      end

      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_FIN);
    end
  end

  assign rom_rd     = rom_rd_q;
  assign rom_addr   = rom_addr_q;
  assign cmd_wr     = cmd_wr_q;
  assign cmd_in     = cmd_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign host_ready = ~slot_full_q;

endmodule

// File: tb/tb_shadowmask_loader.sv
// Directed bench for shadowmask_loader: pattern memory with a programmable
// stall, a write/read logger, and a linear sequence of scenarios.
module tb_shadowmask_loader;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [2:0]  preset   = 3'd0;
  logic [2:0]  cfg      = 3'd0;
  logic        rom_rd;
  logic [7:0]  rom_addr;
  logic        rom_ack  = 1'b0;
  logic [15:0] rom_data = 16'h0000;
  logic        host_wr  = 1'b0;
  logic [15:0] host_cmd = 16'h0000;
  logic        host_ready;
  logic        cmd_wr;
  logic [15:0] cmd_in;
  logic        busy;
  logic        done;

  shadowmask_loader #(.ADDR_W(8), .PRESET_STRIDE(32)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .preset(preset), .cfg(cfg),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .host_wr(host_wr), .host_cmd(host_cmd), .host_ready(host_ready),
    .cmd_wr(cmd_wr), .cmd_in(cmd_in), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference LUT contents and the command each entry must produce.
  function automatic logic [2:0] lut_val(input int idx);
    return 3'((idx * 5 + 3) % 8);
  endfunction

  function automatic logic [15:0] lut_cmd(input int idx);
    return {3'b011, 3'b000, 6'(idx), 1'b0, lut_val(idx)};
  endfunction

  // Pattern memory with an optional stall on one address.
  logic [15:0] mem [256];
  int stall_addr = -1;
  int stall_len  = 0;
  int wait_cnt   = 0;

  always @(negedge clk_sys) begin
    if (rom_rd) begin
      if (wait_cnt >= ((int'(rom_addr) == stall_addr) ? stall_len : 0)) begin
        rom_ack  = 1'b1;
        rom_data = mem[rom_addr];
        wait_cnt = 0;
      end else begin
        rom_ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      rom_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Logger: every command write, every new read address, done pulses, stall stats.
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  int done_cnt     = 0;
  int stall_rd     = 0;
  int stall_wr     = 0;
  bit rd_prev      = 1'b0;
  bit host_with_rd = 1'b0;

  always @(negedge clk_sys) begin
    if (cmd_wr) begin
      wr_log.push_back(cmd_in);
      if (cmd_in == 16'h2002) host_with_rd = rom_rd;
    end
    if (done) done_cnt++;
    if (rom_rd && !rd_prev) rd_log.push_back(rom_addr);
    rd_prev = rom_rd;
    if (rom_rd && rom_addr == 8'd71) begin
      stall_rd++;
      if (cmd_wr) stall_wr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 16'hxxxx;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
  endtask

  logic [15:0] exp_q [$];

  // Expected write stream of one load; host_after >= 0 inserts 0x2002 after that LUT index.
  task automatic build_exp(input int host_after);
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h2003);
    exp_q.push_back(16'h4005);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(lut_cmd(i));
      if (i == host_after) exp_q.push_back(16'h2002);
    end
    exp_q.push_back(16'h0003);
  endtask

  task automatic cmp_stream(input string tag, input int b);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (log_at(b + i) !== exp_q[i]) mism++;
    check({tag, "_stream_mismatches"}, 32'(mism), 32'd0);
  endtask

  task automatic cmp_reads(input string tag, input int rb);
    int mism;
    mism = 0;
    for (int i = 0; i < 17; i++)
      if (rb + i >= rd_log.size() || rd_log[rb + i] !== 8'(64 + i)) mism++;
    check({tag, "_read_count"}, 32'(rd_log.size() - rb), 32'd17);
    check({tag, "_read_addr_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int b, rb, db, sr, sw, bad;
    bit ok, found;

    for (int a = 0; a < 256; a++) mem[a] = 16'h0FFF;
    mem[64] = 16'h0035;
    for (int n = 1; n <= 16; n++) begin
      int i;
      i = 4 * (n - 1);
      mem[64 + n] = {4'b0, lut_val(i + 3), lut_val(i + 2), lut_val(i + 1), lut_val(i)};
    end
    mem[160] = 16'h00FF;

    // Reset state and idle behaviour.
    tick();
    check("rst_ctrl_vec", 32'({cmd_wr, rom_rd, busy, done, host_ready}), 32'b00001);
    check("rst_cmd_in", 32'(cmd_in), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_wr || rom_rd || busy || !host_ready) bad++;
    end
    check("idle_10_cycles", 32'(bad), 32'd0);

    // Two host commands on consecutive idle cycles: first issued, second dropped.
    b = wr_log.size();
    host_wr  = 1'b1;
    host_cmd = 16'h2111;
    tick();
    check("host_ready_drop", 32'(host_ready), 32'd0);
    host_cmd = 16'h2222;
    tick();
    host_wr = 1'b0;
    check("host_issue_wr", 32'(cmd_wr), 32'd1);
    check("host_issue_cmd", 32'(cmd_in), 32'h2111);
    check("host_ready_back", 32'(host_ready), 32'd1);
    repeat (5) tick();
    check("host_second_dropped", 32'(wr_log.size() - b), 32'd1);

    // Load A: preset 2, cfg 3'b011, zero-wait memory.
    b = wr_log.size(); rb = rd_log.size(); db = done_cnt;
    preset = 3'd2; cfg = 3'b011; start = 1'b1;
    tick();
    start = 1'b0; preset = 3'd0; cfg = 3'd0;
    check("a_start_latency", 32'(cmd_wr), 32'd1);
    check("a_dis_cmd", 32'(cmd_in), 32'h0000);
    check("a_busy_set", 32'(busy), 32'd1);
    wait_done(ok);
    check("a_done_seen", 32'(ok), 32'd1);
    tick();
    check("a_busy_clear", 32'(busy), 32'd0);
    build_exp(-1);
    check("a_write_count", 32'(wr_log.size() - b), 32'd68);
    check("a_vmax_cmd", 32'(log_at(b + 1)), 32'h2003);
    check("a_hmax_cmd", 32'(log_at(b + 2)), 32'h4005);
    check("a_final_ctrl", 32'(log_at(b + 67)), 32'h0003);
    cmp_stream("a", b);
    cmp_reads("a", rb);
    check("a_done_once", 32'(done_cnt - db), 32'd1);

    // Load B: 5-cycle stall on address 71, host command and ignored start mid-load.
    stall_addr = 71; stall_len = 4;
    b = wr_log.size(); rb = rd_log.size(); db = done_cnt; sr = stall_rd; sw = stall_wr;
    preset = 3'd2; cfg = 3'b011; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (cmd_wr && cmd_in == lut_cmd(8)) found = 1'b1;
    end
    check("b_lut8_seen", 32'(found), 32'd1);
    host_wr = 1'b1; host_cmd = 16'h2002;
    start = 1'b1; preset = 3'd5; cfg = 3'b111;
    tick();
    host_wr = 1'b0; start = 1'b0; preset = 3'd0; cfg = 3'd0;
    check("b_host_ready_low", 32'(host_ready), 32'd0);
    wait_done(ok);
    check("b_done_seen", 32'(ok), 32'd1);
    build_exp(11);
    check("b_write_count", 32'(wr_log.size() - b), 32'd69);
    cmp_stream("b", b);
    check("b_lut24_after_stall", 32'(log_at(b + 3 + 24 + 1)), 32'(lut_cmd(24)));
    check("b_host_during_fetch", 32'(host_with_rd), 32'd1);
    check("b_stall_rd_cycles", 32'(stall_rd - sr), 32'd5);
    check("b_stall_no_writes", 32'(stall_wr - sw), 32'd0);
    cmp_reads("b", rb);
    check("b_done_once", 32'(done_cnt - db), 32'd1);
    b = wr_log.size();
    repeat (6) tick();
    check("b_restart_ignored", 32'({busy, 1'b0} | 2'(wr_log.size() - b)), 32'd0);
    stall_addr = -1; stall_len = 0;

    // Load C: reset asserted during the 30th loader write.
    b = wr_log.size();
    preset = 3'd2; cfg = 3'b011; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (wr_log.size() - b >= 30) found = 1'b1;
      else tick();
    end
    check("c_reached_write30", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    check("c_rst_ctrl_vec", 32'({cmd_wr, rom_rd, busy, done, host_ready}), 32'b00001);
    check("c_rst_cmd_in", 32'(cmd_in), 32'h0);
    check("c_rst_rom_addr", 32'(rom_addr), 32'h0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("c_no_writes_after_abort", 32'(wr_log.size() - b), 32'd30);
    check("c_idle_after_abort", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
